// File: rtl/mem_access.sv
// Memory-access stage: registers one execute op, runs the data-memory handshake, returns a
// lane-aligned load word to writeback. Optional trap on misaligned accesses: MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic          in_is_mem,
   input  logic [3:0]    in_op_spec,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_wdat,
   input  logic          flush,
   input  logic          stall_in_bk,
   output logic          stall_out_bk,
   output logic          dmem_req_valid,
   input  logic          dmem_req_ready,
   output logic [AW-1:0] dmem_addr,
   output logic          dmem_we,
   output logic [3:0]    dmem_be,
   output logic [DW-1:0] dmem_wdat,
   input  logic          dmem_rsp_valid,
   input  logic [DW-1:0] dmem_rsp_dat,
   output logic          out_valid,
   output logic [DW-1:0] out_mem_dat,
   output logic          out_misalign
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_t;

   state_t        state_q;
   logic [AW-1:0] dmem_addr_q;
   logic          dmem_we_q;
   logic [3:0]    dmem_be_q;
   logic [DW-1:0] dmem_wdat_q;
   logic [1:0]    shift_q;
   logic [DW-1:0] out_mem_dat_q;

   logic          in_known;
   logic          in_store;
   logic [3:0]    in_be;
   logic [DW-1:0] in_lane;
   logic [1:0]    in_shift;
   logic          trap;

   // Opcodes 1000-1111 fall back to the non-memory path.
   always_comb begin
      in_known = in_is_mem && !in_op_spec[3];
      in_store = in_op_spec[2] && (in_op_spec[1] || in_op_spec[0]);
      in_be    = 4'b1111;
      in_lane  = in_wdat;
      in_shift = 2'b00;
      unique case (in_op_spec[2:0])
         3'd0, 3'd3, 3'd5: begin
            in_be    = 4'b0001 << in_addr[1:0];
            in_lane  = {4{in_wdat[7:0]}};
            in_shift = in_addr[1:0];
         end
         3'd1, 3'd4, 3'd6: begin
            in_be    = 4'b0011 << {in_addr[1], 1'b0};
            in_lane  = {2{in_wdat[15:0]}};
            in_shift = {in_addr[1], 1'b0};
         end
         3'd2, 3'd7: begin
            in_be    = 4'b1111;
            in_lane  = in_wdat;
            in_shift = 2'b00;
         end
      endcase
   end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   logic is_half;
   logic is_word;
   logic misalign_q;
   assign is_half      = (in_op_spec[2:0] == 3'd1) || (in_op_spec[2:0] == 3'd4) ||
                         (in_op_spec[2:0] == 3'd6);
   assign is_word      = (in_op_spec[2:0] == 3'd2) || (in_op_spec[2:0] == 3'd7);
   assign trap         = in_known && ((is_half && in_addr[0]) || (is_word && (|in_addr[1:0])));
   assign out_misalign = misalign_q;
`else
   assign trap         = 1'b0;
   assign out_misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         dmem_addr_q   <= '0;
         dmem_we_q     <= 1'b0;
         dmem_be_q     <= '0;
         dmem_wdat_q   <= '0;
         shift_q       <= '0;
         out_mem_dat_q <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid && !flush) begin
                  out_mem_dat_q <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                  misalign_q    <= trap;
`endif
                  if (in_known && !trap) begin
                     dmem_addr_q <= {in_addr[AW-1:2], 2'b00};
                     dmem_we_q   <= in_store;
                     dmem_be_q   <= in_be;
                     dmem_wdat_q <= in_lane;
                     shift_q     <= in_shift;
                     state_q     <= StReq;
                  end else begin
                     state_q     <= StDone;
                  end
               end
            end
            StReq: begin
               // A store that handshakes is committed even if flushed.
               if (dmem_req_ready) begin
                  if (flush) state_q <= dmem_we_q ? StIdle : StDrain;
                  else       state_q <= dmem_we_q ? StDone : StWait;
               end else if (flush) begin
                  state_q <= StIdle;
               end
            end
            StWait: begin
               if (flush) begin
                  state_q <= dmem_rsp_valid ? StIdle : StDrain;
               end else if (dmem_rsp_valid) begin
                  out_mem_dat_q <= dmem_rsp_dat >> {shift_q, 3'b000};
                  state_q       <= StDone;
               end
            end
            StDone: begin
               if (flush || !stall_in_bk) begin
                  out_mem_dat_q <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                  misalign_q    <= 1'b0;
`endif
                  state_q       <= StIdle;
               end
            end
            StDrain: begin
               if (dmem_rsp_valid) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign stall_out_bk   = (state_q != StIdle);
   assign dmem_req_valid = (state_q == StReq);
   assign out_valid      = (state_q == StDone);
   assign dmem_addr      = dmem_addr_q;
   assign dmem_we        = dmem_we_q;
   assign dmem_be        = dmem_be_q;
   assign dmem_wdat      = dmem_wdat_q;
   assign out_mem_dat    = out_mem_dat_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table of single-op vectors plus hand-written
// sequences for back-pressure, stalls and flushes.
module tb_mem_access;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_is_mem;
   logic [3:0]  in_op_spec;
   logic [31:0] in_addr;
   logic [31:0] in_wdat;
   logic        flush;
   logic        stall_in_bk;
   logic        stall_out_bk;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdat;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_dat;
   logic        out_valid;
   logic [31:0] out_mem_dat;
   logic        out_misalign;

   int checks   = 0;
   int failures = 0;

   mem_access #(.AW(32), .DW(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_is_mem      (in_is_mem),
      .in_op_spec     (in_op_spec),
      .in_addr        (in_addr),
      .in_wdat        (in_wdat),
      .flush          (flush),
      .stall_in_bk    (stall_in_bk),
      .stall_out_bk   (stall_out_bk),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_addr      (dmem_addr),
      .dmem_we        (dmem_we),
      .dmem_be        (dmem_be),
      .dmem_wdat      (dmem_wdat),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rsp_dat   (dmem_rsp_dat),
      .out_valid      (out_valid),
      .out_mem_dat    (out_mem_dat),
      .out_misalign   (out_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic        is_mem;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [31:0] rsp;
      logic        req;
      logic [31:0] eaddr;
      logic [3:0]  ebe;
      logic        ewe;
      logic [31:0] ewdat;
      logic [31:0] edat;
      logic        emis;
      int          lat;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Issues one op with ready=1 and a response one cycle after a load handshake.
   task automatic do_op(input vec_t v, input int hold, input string tag);
      int          cyc;
      int          nobs;
      logic        seen;
      logic        pend;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        we;
      cyc = 0; seen = 0; pend = 0; a = 0; wd = 0; be = 0; we = 0;
      @(negedge clk);
      in_valid = 1'b1; in_is_mem = v.is_mem; in_op_spec = v.op;
      in_addr = v.addr; in_wdat = v.wdat;
      stall_in_bk = (hold > 0); dmem_req_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         dmem_rsp_valid = pend;
         dmem_rsp_dat   = pend ? v.rsp : 32'h0;
         pend = 1'b0;
         if (out_valid) begin
            cyc = i;
            break;
         end
         if (dmem_req_valid && dmem_req_ready) begin
            seen = 1'b1; a = dmem_addr; be = dmem_be; we = dmem_we; wd = dmem_wdat;
            pend = !dmem_we;
         end
         @(negedge clk);
      end
      dmem_rsp_valid = 1'b0;
      check({tag, " latency"}, cyc, v.lat);
      check({tag, " req_seen"}, {31'b0, seen}, {31'b0, v.req});
      if (v.req) begin
         check({tag, " addr"}, a, v.eaddr);
         check({tag, " be"}, {28'b0, be}, {28'b0, v.ebe});
         check({tag, " we"}, {31'b0, we}, {31'b0, v.ewe});
         if (v.ewe) check({tag, " wdat"}, wd, v.ewdat);
      end
      nobs = (hold > 0) ? hold : 1;
      for (int i = 0; i < nobs; i++) begin
         check({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
         check({tag, " out_mem_dat"}, out_mem_dat, v.edat);
         check({tag, " misalign"}, {31'b0, out_misalign}, {31'b0, v.emis});
         check({tag, " stall_out"}, {31'b0, stall_out_bk}, 32'd1);
         if (i == nobs - 1) stall_in_bk = 1'b0;
         @(negedge clk);
      end
      check({tag, " out_valid_drop"}, {31'b0, out_valid}, 32'd0);
      check({tag, " idle"}, {31'b0, stall_out_bk}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      logic        stable;
      logic        seen_out;
      // op, is_mem, addr, wdat, rsp, req, eaddr, ebe, ewe, ewdat, edat, emis, lat
      vecs[0]  = '{4'd2, 1'b1, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'h0000_1004,
                   4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 3};
      vecs[1]  = '{4'd0, 1'b1, 32'h0000_2003, 32'h0, 32'h8100_0000, 1'b1, 32'h0000_2000,
                   4'b1000, 1'b0, 32'h0, 32'h0000_0081, 1'b0, 3};
      vecs[2]  = '{4'd4, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1'b1, 32'h0000_2000,
                   4'b1100, 1'b0, 32'h0, 32'h0000_BEEF, 1'b0, 3};
      vecs[3]  = '{4'd1, 1'b1, 32'h0000_2000, 32'h0, 32'hBEEF_1234, 1'b1, 32'h0000_2000,
                   4'b0011, 1'b0, 32'h0, 32'hBEEF_1234, 1'b0, 3};
      vecs[4]  = '{4'd3, 1'b1, 32'h0000_2001, 32'h0, 32'h1122_3344, 1'b1, 32'h0000_2000,
                   4'b0010, 1'b0, 32'h0, 32'h0011_2233, 1'b0, 3};
      vecs[5]  = '{4'd5, 1'b1, 32'h0000_3001, 32'h1234_56A5, 32'h0, 1'b1, 32'h0000_3000,
                   4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0, 2};
      vecs[6]  = '{4'd6, 1'b1, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 1'b1, 32'h0000_3000,
                   4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0, 1'b0, 2};
      vecs[7]  = '{4'd7, 1'b1, 32'h0000_3008, 32'hCAFE_F00D, 32'h0, 1'b1, 32'h0000_3008,
                   4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 2};
      vecs[8]  = '{4'd2, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 32'h0,
                   4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, 1};
      vecs[9]  = '{4'd8, 1'b1, 32'h0000_4004, 32'h0, 32'h0, 1'b0, 32'h0,
                   4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, 1};
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      vecs[10] = '{4'd2, 1'b1, 32'h0000_0002, 32'h0, 32'h89AB_CDEF, 1'b0, 32'h0,
                   4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1};
      vecs[11] = '{4'd1, 1'b1, 32'h0000_0003, 32'h0, 32'h89AB_CDEF, 1'b0, 32'h0,
                   4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1};
      vecs[12] = '{4'd7, 1'b1, 32'h0000_3001, 32'h1111_2222, 32'h0, 1'b0, 32'h0,
                   4'b0000, 1'b0, 32'h0, 32'h0, 1'b1, 1};
`else
      vecs[10] = '{4'd2, 1'b1, 32'h0000_0002, 32'h0, 32'h89AB_CDEF, 1'b1, 32'h0000_0000,
                   4'b1111, 1'b0, 32'h0, 32'h89AB_CDEF, 1'b0, 3};
      vecs[11] = '{4'd1, 1'b1, 32'h0000_0003, 32'h0, 32'h89AB_CDEF, 1'b1, 32'h0000_0000,
                   4'b1100, 1'b0, 32'h0, 32'h0000_89AB, 1'b0, 3};
      vecs[12] = '{4'd7, 1'b1, 32'h0000_3001, 32'h1111_2222, 32'h0, 1'b1, 32'h0000_3000,
                   4'b1111, 1'b1, 32'h1111_2222, 32'h0, 1'b0, 2};
`endif

      rst_n = 1'b0; in_valid = 1'b0; in_is_mem = 1'b0; in_op_spec = 4'd0; in_addr = 32'h0;
      in_wdat = 32'h0; flush = 1'b0; stall_in_bk = 1'b0; dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0; dmem_rsp_dat = 32'h0;
      repeat (3) @(negedge clk);
      check("reset stall_out", {31'b0, stall_out_bk}, 32'd0);
      check("reset req_valid", {31'b0, dmem_req_valid}, 32'd0);
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
      check("reset out_mem_dat", out_mem_dat, 32'h0);
      check("reset dmem_addr", dmem_addr, 32'h0);
      check("reset dmem_be", {28'b0, dmem_be}, 32'h0);
      check("reset misalign", {31'b0, out_misalign}, 32'd0);
      rst_n = 1'b1;

      for (int k = 0; k < 13; k++) do_op(vecs[k], 0, $sformatf("vec%0d", k));

      // Held result: writeback stalled for 3 cycles.
      do_op(vecs[1], 3, "hold3");

      // Store with ready low for 4 cycles.
      @(negedge clk);
      in_valid = 1'b1; in_is_mem = 1'b1; in_op_spec = 4'd6; in_addr = 32'h0000_3002;
      in_wdat = 32'h1234_ABCD; dmem_req_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; n = 0; stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) dmem_req_ready = 1'b1;
         if (dmem_req_valid) n++;
         if (dmem_be !== 4'b1100 || dmem_wdat !== 32'hABCD_ABCD || dmem_addr !== 32'h3000 ||
             dmem_we !== 1'b1) stable = 1'b0;
         @(negedge clk);
      end
      check("bp req_cycles", n, 5);
      check("bp req_stable", {31'b0, stable}, 32'd1);
      check("bp req_drop", {31'b0, dmem_req_valid}, 32'd0);
      check("bp out_valid", {31'b0, out_valid}, 32'd1);
      check("bp out_mem_dat", out_mem_dat, 32'h0);
      @(negedge clk);
      check("bp done", {31'b0, out_valid}, 32'd0);

      // Flush while a load waits for its response; the late response is drained.
      dmem_req_ready = 1'b1;
      in_valid = 1'b1; in_is_mem = 1'b1; in_op_spec = 4'd2; in_addr = 32'h0000_1000;
      @(negedge clk);
      in_valid = 1'b0; seen_out = 1'b0;
      check("fw req", {31'b0, dmem_req_valid}, 32'd1);
      @(negedge clk);
      flush = 1'b1;
      seen_out = seen_out | out_valid;
      @(negedge clk);
      flush = 1'b0;
      seen_out = seen_out | out_valid;
      check("fw drain_busy", {31'b0, stall_out_bk}, 32'd1);
      dmem_rsp_valid = 1'b1; dmem_rsp_dat = 32'h5555_5555;
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      seen_out = seen_out | out_valid;
      check("fw idle", {31'b0, stall_out_bk}, 32'd0);
      @(negedge clk);
      seen_out = seen_out | out_valid;
      check("fw no_out", {31'b0, seen_out}, 32'd0);
      do_op(vecs[0], 0, "after_flush");

      // Flush before the handshake cancels the request.
      @(negedge clk);
      dmem_req_ready = 1'b0;
      in_valid = 1'b1; in_is_mem = 1'b1; in_op_spec = 4'd2; in_addr = 32'h0000_1000;
      @(negedge clk);
      in_valid = 1'b0;
      check("fr req", {31'b0, dmem_req_valid}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("fr req_drop", {31'b0, dmem_req_valid}, 32'd0);
      check("fr idle", {31'b0, stall_out_bk}, 32'd0);

      // Flush in IDLE blocks capture.
      in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("fi idle", {31'b0, stall_out_bk}, 32'd0);

      // Flush in DONE drops a stalled result.
      in_valid = 1'b1; in_is_mem = 1'b0; stall_in_bk = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("fd out_valid", {31'b0, out_valid}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; stall_in_bk = 1'b0;
      check("fd drop", {31'b0, out_valid}, 32'd0);
      check("fd idle", {31'b0, stall_out_bk}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory-access stage between execute and writeback; the only block that talks to the data memory port.
- Registers one execute-stage op per accept; for loads/stores, issues a valid/ready request to data memory, waits for load response, and hands writeback a lane-aligned raw word on mem_dat (writeback performs sign/zero extension from the low bits).
- Back-pressures execute via stall_out_bk while an access is in flight.

Parameters:
AW, 32, data-memory address width
DW, 32, data width (only 32 supported; 4 byte lanes)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  execute presents an op this cycle
in_is_mem  input  1  op_type == MEMORY
in_op_spec  input  4  0000 lb, 0001 lh, 0010 lw, 0011 lbu, 0100 lhu, 0101 sb, 0110 sh, 0111 sw
in_addr  input  AW  effective address
in_wdat  input  DW  store data (rs2)
flush  input  1  jump taken in writeback; kill the held op
stall_in_bk  input  1  writeback cannot accept
stall_out_bk  output  1  execute must hold its outputs
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  memory accepts request
dmem_addr  output  AW  word-aligned address
dmem_we  output  1  1 = store
dmem_be  output  4  byte enables
dmem_wdat  output  DW  lane-replicated store data
dmem_rsp_valid  input  1  load data valid
dmem_rsp_dat  input  DW  load word
out_valid  output  1  result for writeback
out_mem_dat  output  DW  load word shifted right by addr[1:0]*8; 0 for stores and non-memory ops
out_misalign  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; captured regs 0.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - IDLE: if in_valid && !flush, capture op_spec/addr/wdat. is_mem → REQ; else → DONE with out_mem_dat=0.
  - REQ: dmem_req_valid=1; addr/we/be/wdat stable until handshake. On handshake (valid && ready): load → WAIT, store → DONE.
  - WAIT: on dmem_rsp_valid, capture rsp_dat >> (addr[1:0]*8) → DONE. rsp_valid in any other state except DRAIN is ignored.
  - DONE: out_valid=1, out_mem_dat held. If !stall_in_bk → IDLE; else stay (output held stable).
- stall_out_bk = (state != IDLE). Combinational, registered-state only; no input-to-output path.
- Flush priority:
  - IDLE: blocks capture.
  - REQ before handshake: → IDLE, no request completes.
  - REQ on handshake cycle, or WAIT: → DRAIN (load) or IDLE (store; store is committed and not undone). DRAIN consumes exactly one rsp_valid, then → IDLE, no out_valid.
  - DONE: → IDLE, out_valid drops next cycle.
- Min latency, accept edge to out_valid: non-mem 1 cycle; store 2 (ready=1); load 3 (ready=1, rsp one cycle after handshake).
- Address/byte-lane rules:
  - dmem_addr = {addr[AW-1:2],2'b00}.
  - Byte ops: be = 4'b0001 << addr[1:0]; wdat = {4{wdat[7:0]}}.
  - Half ops: be = 4'b0011 << {addr[1],1'b0}; wdat = {2{wdat[15:0]}}.
  - Word ops: be = 4'b1111; wdat unchanged.
  - Loads drive be for the accessed bytes, we=0.
- Undefined op_spec (1000–1111) with in_is_mem=1: treated as non-mem (no request, DONE with 0).

Optional Feature:
MEM_ACCESS_MISALIGN_TRAP_EN
- Defined: half ops with addr[0]=1, or word ops with addr[1:0]!=0, issue no request and go IDLE → DONE. out_misalign=1, out_mem_dat=0.
- Undefined: out_misalign tied 0. Misaligned low address bits are ignored for lane selection (half uses addr[1], word uses none), and the request is issued normally.

Test Plan:
- lw addr 0x0000_1004, ready=1, rsp 0xDEAD_BEEF one cycle after handshake → req addr 0x1004 be 1111 we 0; out_valid at accept+3 with out_mem_dat 0xDEADBEEF; stall_out_bk high for 3 cycles.
- lb addr 0x0000_2003, rsp 0x8100_0000 → be 1000; out_mem_dat 0x0000_0081.
- sh addr 0x0000_3002, wdat 0x1234_ABCD, ready low 4 cycles → req_valid held 4+1 cycles with be 1100, wdat 0xABCD_ABCD; no rsp wait; out_valid after handshake+1.
- lw in WAIT, flush=1, then rsp 0x5555_5555 → DRAIN consumes it, out_valid never asserts, returns IDLE; next op accepted normally.
- Result in DONE with stall_in_bk=1 for 3 cycles → out_valid and out_mem_dat stable 3 cycles; stall_out_bk high until release.
- lw addr 0x0000_0002: with MEM_ACCESS_MISALIGN_TRAP_EN → no dmem_req_valid, out_misalign=1, out_mem_dat 0; without → req addr 0x0 be 1111, out_misalign 0.
